// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared machine-mode CSR constants: the CSR address map, the mstatus
// writable-field mask and fixed MPP value, trap cause codes, and small helper
// functions used by the CSR register file and the WBU write logic.
// No ports (package).
// -----------------------------------------------------------------------------
package csr_pkg;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    // mstatus: only MIE (bit 3) and MPIE (bit 7) are writable; MPP is hardwired
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [1:0]  MSTATUS_MPP   = 2'b11;

    // Trap cause codes
    localparam logic [31:0] ILLEGAL_INSN  = 32'h0000_0002;
    localparam logic [31:0] BREAKPOINT    = 32'h0000_0003;
    localparam logic [31:0] ECALL_M       = 32'h0000_000b;

    // Architecturally visible mstatus: writable bits plus the fixed MPP field
    function automatic logic [31:0] mstatus_view(input logic [31:0] raw);
        return (raw & MSTATUS_WMASK) | {19'd0, MSTATUS_MPP, 11'd0};
    endfunction

    // Merge a write into mstatus, touching only the writable bits
    function automatic logic [31:0] mstatus_merge(input logic [31:0] old_val,
                                                  input logic [31:0] wdata);
        return (old_val & ~MSTATUS_WMASK) | (wdata & MSTATUS_WMASK);
    endfunction

    // Resolve both write ports against one CSR address: {write_enable, data}.
    // Port 2 has priority when both target the same address.
    function automatic logic [32:0] csr_write_sel(input logic        en1,
                                                  input logic [11:0] a1,
                                                  input logic [31:0] d1,
                                                  input logic        en2,
                                                  input logic [11:0] a2,
                                                  input logic [31:0] d2,
                                                  input logic [11:0] target);
        if (en2 && (a2 == target)) begin
            return {1'b1, d2};
        end else if (en1 && (a1 == target)) begin
            return {1'b1, d1};
        end else begin
            return {1'b0, 32'd0};
        end
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// -----------------------------------------------------------------------------
// csr_counter64
// Free-running 64-bit counter (mcycle) with independent loads of the low and
// high words. Built only when CSR_MCYCLE_EN is defined in the including build.
//   clk      : core clock
//   rst_n    : synchronous active-low reset (count returns to 0)
//   load_lo  : replace the low word with lo_data (high word holds, no carry)
//   load_hi  : replace the high word with hi_data (low word keeps counting)
//   lo_data  : low-word load value
//   hi_data  : high-word load value
//   count    : current 64-bit count, registered
// -----------------------------------------------------------------------------
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] lo_data,
    input  logic [31:0] hi_data,
    output logic [63:0] count
);

    logic [31:0] lo_r;
    logic [31:0] hi_r;
    logic [32:0] lo_inc_s;
    logic [31:0] lo_nxt_s;
    logic [31:0] hi_nxt_s;

    // Low word plus one, with carry-out in bit 32
    assign lo_inc_s = {1'b0, lo_r} + 33'd1;

    // Next-state selection: a loaded half never increments, and a loaded low
    // word suppresses the carry into the high word for that cycle
    always_comb begin
        lo_nxt_s = lo_inc_s[31:0];
        hi_nxt_s = hi_r;
        if (load_lo) begin
            lo_nxt_s = lo_data;
        end else begin
            lo_nxt_s = lo_inc_s[31:0];
        end
        if (load_hi) begin
            hi_nxt_s = hi_data;
        end else if (load_lo) begin
            hi_nxt_s = hi_r;
        end else begin
            hi_nxt_s = hi_r + {31'd0, lo_inc_s[32]};
        end
    end

    // Counter state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_r <= 32'd0;
            hi_r <= 32'd0;
        end else begin
            lo_r <= lo_nxt_s;
            hi_r <= hi_nxt_s;
        end
    end

    assign count = {hi_r, lo_r};

endmodule

// File: rtl/csr_regfile.sv
// -----------------------------------------------------------------------------
// csr_regfile
// Machine-mode CSR storage: mstatus, mtvec, mepc, mcause and (optionally) the
// 64-bit mcycle counter. Two independent write ports commit on the clock edge
// (port 2 wins on an address collision); one combinational read port; mtvec
// and mepc are exported for trap entry / mret redirection.
// Build option: CSR_MCYCLE_EN -- when defined, mcycle/mcycleh are implemented
// by csr_counter64; otherwise 0xB00/0xB80 read 0 and writes to them drop.
// Ports:
//   i_clk, i_rst_n                : clock, synchronous active-low reset
//   i_wena1/i_waddr1/i_wdata1     : write port 1
//   i_wena2/i_waddr2/i_wdata2     : write port 2 (priority on collision)
//   i_raddr -> o_rdata/o_rillegal : combinational read, illegal flag
//   o_mtvec, o_mepc               : registered trap vector / exception PC
// -----------------------------------------------------------------------------
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wena1,
    input  logic [11:0] i_waddr1,
    input  logic [31:0] i_wdata1,
    input  logic        i_wena2,
    input  logic [11:0] i_waddr2,
    input  logic [31:0] i_wdata2,
    input  logic [11:0] i_raddr,
    output logic [31:0] o_rdata,
    output logic        o_rillegal,
    output logic [31:0] o_mtvec,
    output logic [31:0] o_mepc
);

    logic [31:0] mstatus_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;

    logic        mstatus_we_s;
    logic [31:0] mstatus_wd_s;
    logic        mtvec_we_s;
    logic [31:0] mtvec_wd_s;
    logic        mepc_we_s;
    logic [31:0] mepc_wd_s;
    logic        mcause_we_s;
    logic [31:0] mcause_wd_s;

    logic [31:0] rdata_s;
    logic        rillegal_s;

    // Per-register write decode; unmapped and read-only addresses match nothing
    assign {mstatus_we_s, mstatus_wd_s} = csr_write_sel(i_wena1, i_waddr1, i_wdata1,
                                                        i_wena2, i_waddr2, i_wdata2, CSR_MSTATUS);
    assign {mtvec_we_s, mtvec_wd_s}     = csr_write_sel(i_wena1, i_waddr1, i_wdata1,
                                                        i_wena2, i_waddr2, i_wdata2, CSR_MTVEC);
    assign {mepc_we_s, mepc_wd_s}       = csr_write_sel(i_wena1, i_waddr1, i_wdata1,
                                                        i_wena2, i_waddr2, i_wdata2, CSR_MEPC);
    assign {mcause_we_s, mcause_wd_s}   = csr_write_sel(i_wena1, i_waddr1, i_wdata1,
                                                        i_wena2, i_waddr2, i_wdata2, CSR_MCAUSE);

    // Architectural CSR registers; reset wins over any same-cycle write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mstatus_r <= MSTATUS_RST;
            mtvec_r   <= MTVEC_RST;
            mepc_r    <= 32'd0;
            mcause_r  <= 32'd0;
        end else begin
            if (mstatus_we_s) begin
                mstatus_r <= mstatus_merge(mstatus_r, mstatus_wd_s);
            end
            if (mtvec_we_s) begin
                // direct mode only: vector base is word aligned
                mtvec_r <= {mtvec_wd_s[31:2], 2'b00};
            end
            if (mepc_we_s) begin
                mepc_r <= {mepc_wd_s[31:2], 2'b00};
            end
            if (mcause_we_s) begin
                mcause_r <= mcause_wd_s;
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    logic        cyc_lo_we_s;
    logic [31:0] cyc_lo_wd_s;
    logic        cyc_hi_we_s;
    logic [31:0] cyc_hi_wd_s;
    logic [63:0] mcycle_s;

    assign {cyc_lo_we_s, cyc_lo_wd_s} = csr_write_sel(i_wena1, i_waddr1, i_wdata1,
                                                      i_wena2, i_waddr2, i_wdata2, CSR_MCYCLE);
    assign {cyc_hi_we_s, cyc_hi_wd_s} = csr_write_sel(i_wena1, i_waddr1, i_wdata1,
                                                      i_wena2, i_waddr2, i_wdata2, CSR_MCYCLEH);

    csr_counter64 u_mcycle (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load_lo (cyc_lo_we_s),
        .load_hi (cyc_hi_we_s),
        .lo_data (cyc_lo_wd_s),
        .hi_data (cyc_hi_wd_s),
        .count   (mcycle_s)
    );
`endif

    // Combinational read mux; the counter addresses stay legal even when the
    // counter is not built, they simply read as zero
    always_comb begin
        rdata_s    = 32'd0;
        rillegal_s = 1'b0;
        case (i_raddr)
            CSR_MSTATUS: rdata_s = mstatus_view(mstatus_r);
            CSR_MTVEC:   rdata_s = mtvec_r;
            CSR_MEPC:    rdata_s = mepc_r;
            CSR_MCAUSE:  rdata_s = mcause_r;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE:  rdata_s = mcycle_s[31:0];
            CSR_MCYCLEH: rdata_s = mcycle_s[63:32];
`else
            CSR_MCYCLE:  rdata_s = 32'd0;
            CSR_MCYCLEH: rdata_s = 32'd0;
`endif
            CSR_MVENDORID, CSR_MARCHID: rdata_s = 32'd0;
            default: begin
                rdata_s    = 32'd0;
                rillegal_s = 1'b1;
            end
        endcase
    end

    assign o_rdata    = rdata_s;
    assign o_rillegal = rillegal_s;
    assign o_mtvec    = mtvec_r;
    assign o_mepc     = mepc_r;

endmodule

// File: tb/tb_csr_regfile.sv
// -----------------------------------------------------------------------------
// tb_csr_regfile
// Self-checking bench for csr_regfile: a directed vector table, hand-written
// counter / reset sequences, and a randomized run compared every cycle
// against a behavioural model of the CSR set. Counter expectations follow
// CSR_MCYCLE_EN.
// -----------------------------------------------------------------------------
module tb_csr_regfile;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_wena1;
    logic [11:0] i_waddr1;
    logic [31:0] i_wdata1;
    logic        i_wena2;
    logic [11:0] i_waddr2;
    logic [31:0] i_wdata2;
    logic [11:0] i_raddr;
    logic [31:0] o_rdata;
    logic        o_rillegal;
    logic [31:0] o_mtvec;
    logic [31:0] o_mepc;

`ifdef CSR_MCYCLE_EN
    localparam bit HAS_CYC = 1'b1;
`else
    localparam bit HAS_CYC = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    csr_regfile dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wena1    (i_wena1),
        .i_waddr1   (i_waddr1),
        .i_wdata1   (i_wdata1),
        .i_wena2    (i_wena2),
        .i_waddr2   (i_waddr2),
        .i_wdata2   (i_wdata2),
        .i_raddr    (i_raddr),
        .o_rdata    (o_rdata),
        .o_rillegal (o_rillegal),
        .o_mtvec    (o_mtvec),
        .o_mepc     (o_mepc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the architectural state
    logic        m_mie;
    logic        m_mpie;
    logic [31:0] m_mtvec;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [63:0] m_cyc;

    typedef struct {
        logic        e1;
        logic [11:0] a1;
        logic [31:0] d1;
        logic        e2;
        logic [11:0] a2;
        logic [31:0] d2;
        logic [11:0] ra;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e1, input logic [11:0] a1, input logic [31:0] d1,
                                input logic e2, input logic [11:0] a2, input logic [31:0] d2,
                                input logic [11:0] ra, input logic [31:0] exp_rd,
                                input logic exp_ill);
        vec_t v;
        v.e1 = e1; v.a1 = a1; v.d1 = d1;
        v.e2 = e2; v.a2 = a2; v.d2 = d2;
        v.ra = ra; v.exp_rd = exp_rd; v.exp_ill = exp_ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mie    = 1'b0;
        m_mpie   = 1'b0;
        m_mtvec  = 32'd0;
        m_mepc   = 32'd0;
        m_mcause = 32'd0;
        m_cyc    = 64'd0;
    endtask

    // {illegal, data} for a read of address a in the model
    function automatic logic [32:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b0, 32'h0000_1800 | {24'd0, m_mpie, 3'd0, m_mie, 3'd0}};
            12'h305: return {1'b0, m_mtvec};
            12'h341: return {1'b0, m_mepc};
            12'h342: return {1'b0, m_mcause};
            12'hB00: return {1'b0, HAS_CYC ? m_cyc[31:0] : 32'd0};
            12'hB80: return {1'b0, HAS_CYC ? m_cyc[63:32] : 32'd0};
            12'hF11, 12'hF12: return {1'b0, 32'd0};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Clock-edge update of the model from the driven inputs
    task automatic model_commit();
        logic        en[2];
        logic [11:0] ad[2];
        logic [31:0] dt[2];
        logic [63:0] nxt;
        bit          lo_w;
        bit          hi_w;
        if (!i_rst_n) begin
            model_reset();
        end else begin
            en[0] = i_wena1; ad[0] = i_waddr1; dt[0] = i_wdata1;
            en[1] = i_wena2; ad[1] = i_waddr2; dt[1] = i_wdata2;
            nxt  = m_cyc + 64'd1;
            lo_w = 1'b0;
            hi_w = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (en[p]) begin
                    case (ad[p])
                        12'h300: begin m_mie = dt[p][3]; m_mpie = dt[p][7]; end
                        12'h305: m_mtvec  = dt[p] & 32'hFFFF_FFFC;
                        12'h341: m_mepc   = dt[p] & 32'hFFFF_FFFC;
                        12'h342: m_mcause = dt[p];
                        12'hB00: begin nxt[31:0]  = dt[p]; lo_w = 1'b1; end
                        12'hB80: begin nxt[63:32] = dt[p]; hi_w = 1'b1; end
                        default: ;
                    endcase
                end
            end
            if (lo_w && !hi_w) nxt[63:32] = m_cyc[63:32];
            m_cyc = nxt;
        end
    endtask

    task automatic model_check();
        logic [32:0] r;
        r = model_read(i_raddr);
        check($sformatf("model rdata @%h", i_raddr), o_rdata, r[31:0]);
        check($sformatf("model rillegal @%h", i_raddr), {31'd0, o_rillegal}, {31'd0, r[32]});
        check("model o_mtvec", o_mtvec, m_mtvec);
        check("model o_mepc", o_mepc, m_mepc);
    endtask

    // Drive one cycle's inputs away from the active edge, then check outputs
    task automatic drive(input logic rst, input logic e1, input logic [11:0] a1,
                         input logic [31:0] d1, input logic e2, input logic [11:0] a2,
                         input logic [31:0] d2, input logic [11:0] ra);
        @(negedge i_clk);
        i_rst_n  = rst;
        i_wena1  = e1; i_waddr1 = a1; i_wdata1 = d1;
        i_wena2  = e2; i_waddr2 = a2; i_wdata2 = d2;
        i_raddr  = ra;
        #1;
        model_check();
    endtask

    task automatic commit();
        @(posedge i_clk);
        model_commit();
    endtask

    // Re-point the read port mid-cycle and check against a hand value
    task automatic peek(input string name, input logic [11:0] ra, input logic [31:0] exp);
        i_raddr = ra;
        #1;
        check(name, o_rdata, exp);
        model_check();
    endtask

    task automatic idle(input logic [11:0] ra);
        drive(1'b1, 1'b0, 12'h000, 32'd0, 1'b0, 12'h000, 32'd0, ra);
    endtask

    logic [11:0] addr_pool[11] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                                   12'hF11, 12'hF12, 12'h7C0, 12'h000, 12'h301};

    initial begin
        logic        re1, re2, rrst;
        logic [11:0] ra1, ra2, rra;

        i_rst_n = 1'b0;
        i_wena1 = 1'b0; i_waddr1 = 12'h000; i_wdata1 = 32'd0;
        i_wena2 = 1'b0; i_waddr2 = 12'h000; i_wdata2 = 32'd0;
        i_raddr = 12'h300;
        repeat (2) @(posedge i_clk);
        model_reset();

        // Directed table: exp_rd is the read value in the vector's own cycle
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h300, 32'h0000_1800, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h305, 32'h0, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h341, 32'h0, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h342, 32'h0, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'hF11, 32'h0, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'hF12, 32'h0, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h7C0, 32'h0, 1));
        vecs.push_back(mk(1, 12'h341, 32'h8000_0107, 0, 12'h000, 32'h0, 12'h341, 32'h0, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h341, 32'h8000_0104, 0));
        vecs.push_back(mk(1, 12'h342, 32'h5, 1, 12'h342, 32'h0000_000b, 12'h342, 32'h0, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h342, 32'h0000_000b, 0));
        vecs.push_back(mk(1, 12'h342, 32'h7, 0, 12'h000, 32'h0, 12'h342, 32'h0000_000b, 0));
        vecs.push_back(mk(1, 12'h341, 32'h8000_0010, 1, 12'h342, 32'h0000_000b, 12'h341, 32'h8000_0104, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h342, 32'h0000_000b, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h341, 32'h8000_0010, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 1, 12'h300, 32'h80, 12'h300, 32'h0000_1800, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h300, 32'h0000_1880, 0));
        vecs.push_back(mk(1, 12'h300, 32'hFFFF_FFFF, 0, 12'h000, 32'h0, 12'h300, 32'h0000_1880, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h300, 32'h0000_1888, 0));
        vecs.push_back(mk(1, 12'h305, 32'h1234_5677, 0, 12'h000, 32'h0, 12'h305, 32'h0, 0));
        vecs.push_back(mk(1, 12'hF11, 32'h0000_DEAD, 0, 12'h000, 32'h0, 12'h305, 32'h1234_5674, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'hF11, 32'h0, 0));
        vecs.push_back(mk(1, 12'h7C0, 32'h1, 0, 12'h000, 32'h0, 12'h7C0, 32'h0, 1));
        vecs.push_back(mk(1, 12'h305, 32'h100, 1, 12'h341, 32'h203, 12'h305, 32'h1234_5674, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h341, 32'h0000_0200, 0));
        vecs.push_back(mk(0, 12'h000, 32'h0, 0, 12'h000, 32'h0, 12'h305, 32'h0000_0100, 0));

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].e1, vecs[i].a1, vecs[i].d1,
                  vecs[i].e2, vecs[i].a2, vecs[i].d2, vecs[i].ra);
            check($sformatf("vec%0d rdata", i), o_rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d rillegal", i), {31'd0, o_rillegal}, {31'd0, vecs[i].exp_ill});
            commit();
        end

        // mcycle low-word load and carry into the high word
        drive(1'b1, 1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0, 12'h000, 32'd0, 12'hB00);
        commit();
        idle(12'hB00);
        check("cyc lo after load", o_rdata, HAS_CYC ? 32'hFFFF_FFFE : 32'd0);
        commit();
        idle(12'hB00);
        check("cyc lo +1", o_rdata, HAS_CYC ? 32'hFFFF_FFFF : 32'd0);
        commit();
        idle(12'hB80);
        check("cyc hi carry", o_rdata, HAS_CYC ? 32'd1 : 32'd0);
        check("cyc hi legal", {31'd0, o_rillegal}, 32'd0);
        peek("cyc lo wrapped", 12'hB00, 32'd0);
        commit();

        // both halves loaded together: no increment that cycle
        drive(1'b1, 1'b1, 12'hB00, 32'h10, 1'b1, 12'hB80, 32'h20, 12'hB00);
        commit();
        idle(12'hB00);
        check("cyc dual lo", o_rdata, HAS_CYC ? 32'h10 : 32'd0);
        peek("cyc dual hi", 12'hB80, HAS_CYC ? 32'h20 : 32'd0);
        commit();
        idle(12'hB00);
        check("cyc dual lo +1", o_rdata, HAS_CYC ? 32'h11 : 32'd0);
        commit();

        // 64-bit wrap
        drive(1'b1, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b1, 12'hB80, 32'hFFFF_FFFF, 12'hB00);
        commit();
        idle(12'hB00);
        check("cyc max lo", o_rdata, HAS_CYC ? 32'hFFFF_FFFF : 32'd0);
        peek("cyc max hi", 12'hB80, HAS_CYC ? 32'hFFFF_FFFF : 32'd0);
        commit();
        idle(12'hB00);
        check("cyc wrap lo", o_rdata, 32'd0);
        peek("cyc wrap hi", 12'hB80, 32'd0);
        commit();

        // high-word load while the low word keeps counting (low is 1 here)
        drive(1'b1, 1'b0, 12'h000, 32'd0, 1'b1, 12'hB80, 32'h7, 12'hB00);
        commit();
        idle(12'hB80);
        check("cyc hi load", o_rdata, HAS_CYC ? 32'h7 : 32'd0);
        peek("cyc lo keeps counting", 12'hB00, HAS_CYC ? 32'h2 : 32'd0);
        commit();

        // reset in the same cycle as an mtvec write: write is lost
        drive(1'b0, 1'b1, 12'h305, 32'h0000_0040, 1'b1, 12'h341, 32'h0000_0080, 12'h305);
        commit();
        idle(12'h305);
        check("rst mtvec rdata", o_rdata, 32'd0);
        check("rst o_mtvec", o_mtvec, 32'd0);
        check("rst o_mepc", o_mepc, 32'd0);
        peek("rst mstatus", 12'h300, 32'h0000_1800);
        peek("rst mcycle lo", 12'hB00, 32'd0);
        commit();

        // randomized run against the model
        for (int n = 0; n < 400; n++) begin
            rrst = ($urandom_range(0, 39) != 0);
            re1  = $urandom_range(0, 1) == 1;
            re2  = $urandom_range(0, 1) == 1;
            ra1  = addr_pool[$urandom_range(0, 10)];
            ra2  = ($urandom_range(0, 3) == 0) ? ra1 : addr_pool[$urandom_range(0, 10)];
            rra  = addr_pool[$urandom_range(0, 10)];
            drive(rrst, re1, ra1, $urandom, re2, ra2, $urandom, rra);
            commit();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
